program_loader: RTL and testbench

Host-side loader that drives the CPU's external RAM port (DATA, ADDRESS, EXT_RAM_RW, EXT_RAM_EN, HALT) to write a program image into RAM. It accepts 16-bit words over a valid/ready stream and holds the CPU in HALT for the whole transfer. It writes each word to consecutive addresses with a setup/strobe/hold sequence, then releases HALT so the CPU runs from reset state. It sits beside `bat_amateur` in the system top, and its outputs connect one-to-one to the CPU's external port.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader.sv | 106 ++++++++++
 tb/tb_program_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the CPU program loader: FSM encoding and RAM direction level.
// No logic here beyond a small state-class helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HALT_SETUP = 3'd1,
        ST_WAIT_WORD  = 3'd2,
        ST_WR_SETUP   = 3'd3,
        ST_WR_STROBE  = 3'd4,
        ST_WR_HOLD    = 3'd5,
        ST_RELEASE    = 3'd6
    } state_t;

    // EXT_RAM_RW level that selects a RAM write; the read level is its inverse.
    localparam logic RW_WRITE_LVL = 1'b1;

    function automatic logic is_write_phase(input state_t s);
        return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Purpose: streams 16-bit words into CPU RAM at consecutive addresses while holding the CPU in HALT.
// Latency: HALT one cycle after LOAD_START; 4 cycles per word; DONE/ABORTED 4N+2 cycles after start.
// Backpressure: WORD_READY only in WAIT_WORD and gated by ABORT; a stalled stream simply parks the FSM.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic        RW_WRITE   = RW_WRITE_LVL
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD_START,
    input  logic [15:0] LOAD_LEN,
    input  logic        ABORT,
    input  logic [15:0] WORD_IN,
    input  logic        WORD_VALID,
    output logic        WORD_READY,
    output logic        HALT,
    output logic [15:0] DATA,
    output logic [15:0] ADDRESS,
    output logic        EXT_RAM_RW,
    output logic        EXT_RAM_EN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ABORTED,
    output logic [15:0] CHECKSUM
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] remaining;
    logic        aborted;
    logic        accept;
    logic        start_ok;
    logic        zero_len;
    logic        last_word;
    logic        abortable;

    assign WORD_READY = (state == ST_WAIT_WORD) && !ABORT;
    assign accept     = WORD_READY && WORD_VALID;
    assign start_ok   = (state == ST_IDLE) && LOAD_START && (LOAD_LEN != 16'd0);
    assign zero_len   = (state == ST_IDLE) && LOAD_START && (LOAD_LEN == 16'd0);
    assign last_word  = (remaining == 16'd1);
    assign abortable  = (state != ST_IDLE) && (state != ST_RELEASE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (start_ok) state_nxt = ST_HALT_SETUP;
            ST_HALT_SETUP: state_nxt = ABORT ? ST_RELEASE : ST_WAIT_WORD;
            ST_WAIT_WORD: begin
                if (ABORT)       state_nxt = ST_RELEASE;
                else if (accept) state_nxt = ST_WR_SETUP;
            end
            // Abort before the strobe drops the pending write.
            ST_WR_SETUP:   state_nxt = ABORT ? ST_RELEASE : ST_WR_STROBE;
            ST_WR_STROBE:  state_nxt = ST_WR_HOLD;
            ST_WR_HOLD:    state_nxt = (aborted || ABORT || last_word) ? ST_RELEASE : ST_WAIT_WORD;
            ST_RELEASE:    state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            remaining  <= 16'd0;
            aborted    <= 1'b0;
            HALT       <= 1'b0;
            BUSY       <= 1'b0;
            EXT_RAM_EN <= 1'b0;
            EXT_RAM_RW <= ~RW_WRITE;
            DATA       <= 16'd0;
            ADDRESS    <= START_ADDR;
            CHECKSUM   <= 16'd0;
            DONE       <= 1'b0;
            ABORTED    <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Outputs are decoded from the next state so they line up with the state they describe.
            HALT       <= (state_nxt != ST_IDLE);
            BUSY       <= (state_nxt != ST_IDLE);
            EXT_RAM_EN <= (state_nxt == ST_WR_STROBE);
            EXT_RAM_RW <= is_write_phase(state_nxt) ? RW_WRITE : ~RW_WRITE;
            DONE       <= zero_len || ((state == ST_RELEASE) && !aborted);
            ABORTED    <= (state == ST_RELEASE) && aborted;

            if (start_ok) begin
                remaining <= LOAD_LEN;
                ADDRESS   <= START_ADDR;
                CHECKSUM  <= 16'd0;
                aborted   <= 1'b0;
            end
            if (ABORT && abortable) aborted <= 1'b1;
            if (accept) begin
                DATA     <= WORD_IN;
                CHECKSUM <= CHECKSUM + WORD_IN;
            end
            if (state == ST_WR_HOLD) begin
                ADDRESS   <= ADDRESS + 16'd1;
                remaining <= remaining - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a transaction-level model predicts RAM writes and end events,
// one compare process checks them every cycle, and literal timing/checksum values pin the model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_a, ls_b, abort, valid;
    logic [15:0] load_len, word_in;

    logic        rdy_a, halt_a, rw_a, en_a, busy_a, done_a, ab_a;
    logic [15:0] data_a, addr_a, cs_a;
    logic        rdy_b, halt_b, rw_b, en_b, busy_b, done_b, ab_b;
    logic [15:0] data_b, addr_b, cs_b;

    int checks   = 0;
    int failures = 0;

    logic [15:0] words [4];
    logic [15:0] last_cs [2];
    logic [31:0] exp_wr_a [$];
    logic [31:0] exp_wr_b [$];
    logic [16:0] exp_end_a [$];
    logic [16:0] exp_end_b [$];

    always #5 clk = ~clk;

    program_loader u_dut (
        .CLK(clk), .RST(rst_n), .LOAD_START(ls_a), .LOAD_LEN(load_len), .ABORT(abort),
        .WORD_IN(word_in), .WORD_VALID(valid), .WORD_READY(rdy_a), .HALT(halt_a),
        .DATA(data_a), .ADDRESS(addr_a), .EXT_RAM_RW(rw_a), .EXT_RAM_EN(en_a),
        .BUSY(busy_a), .DONE(done_a), .ABORTED(ab_a), .CHECKSUM(cs_a)
    );

    program_loader #(.START_ADDR(16'hFFFE)) u_wrap (
        .CLK(clk), .RST(rst_n), .LOAD_START(ls_b), .LOAD_LEN(load_len), .ABORT(abort),
        .WORD_IN(word_in), .WORD_VALID(valid), .WORD_READY(rdy_b), .HALT(halt_b),
        .DATA(data_b), .ADDRESS(addr_b), .EXT_RAM_RW(rw_b), .EXT_RAM_EN(en_b),
        .BUSY(busy_b), .DONE(done_b), .ABORTED(ab_b), .CHECKSUM(cs_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a load of len words from base writes words[j] at base+j (16-bit wrap) for each completed
    // write, and ends with DONE/ABORTED carrying the sum of the accepted words.
    task automatic expect_load(input bit inst, input logic [15:0] base, input int len,
                               input int n_wr, input int n_acc, input bit ab);
        logic [15:0] cs;
        cs = 16'd0;
        for (int j = 0; j < n_wr; j++) begin
            if (inst) exp_wr_b.push_back({base + 16'(j), words[j]});
            else      exp_wr_a.push_back({base + 16'(j), words[j]});
        end
        if (len == 0) cs = last_cs[inst];
        else for (int j = 0; j < n_acc; j++) cs = cs + words[j];
        last_cs[inst] = cs;
        if (inst) exp_end_b.push_back({ab, cs});
        else      exp_end_a.push_back({ab, cs});
    endtask

    always @(negedge clk) begin
        logic [31:0] w;
        logic [16:0] e;
        if (en_a) begin
            if (exp_wr_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_write actual=%0h expected=none", {addr_a, data_a});
            end else begin
                w = exp_wr_a.pop_front();
                chk("a_write_addr_data", {addr_a, data_a}, w);
                chk("a_write_halt_rw", {30'd0, halt_a, rw_a}, 32'd3);
            end
        end
        if (done_a || ab_a) begin
            if (exp_end_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_end actual=%0h expected=none", {ab_a, cs_a});
            end else begin
                e = exp_end_a.pop_front();
                chk("a_end_kind_checksum", {15'd0, ab_a, cs_a}, {15'd0, e});
                chk("a_end_done_xor_aborted", {31'd0, done_a ^ ab_a}, 32'd1);
            end
        end
        if (en_b) begin
            if (exp_wr_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_write actual=%0h expected=none", {addr_b, data_b});
            end else begin
                w = exp_wr_b.pop_front();
                chk("b_write_addr_data", {addr_b, data_b}, w);
                chk("b_write_halt_rw", {30'd0, halt_b, rw_b}, 32'd3);
            end
        end
        if (done_b || ab_b) begin
            if (exp_end_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_end actual=%0h expected=none", {ab_b, cs_b});
            end else begin
                e = exp_end_b.pop_front();
                chk("b_end_kind_checksum", {15'd0, ab_b, cs_b}, {15'd0, e});
            end
        end
    end

    // Called just after a rising edge. t_done counts edges from the LOAD_START edge to the cycle
    // showing DONE/ABORTED; halt_cyc and en_cnt count cycles with HALT / EXT_RAM_EN high.
    task automatic run_load(input bit inst, input int len, input int gap, input int abort_idx,
                            input int abort_dly, output int t_done, output int halt_cyc,
                            output int en_cnt);
        int cyc, i, stall, abort_cyc;
        bit acc, ended;
        t_done = -1; halt_cyc = 0; en_cnt = 0;
        load_len = len[15:0];
        if (inst) ls_b = 1'b1; else ls_a = 1'b1;
        @(posedge clk); #1;
        ls_a = 1'b0; ls_b = 1'b0;
        cyc = 0; i = 0; stall = 0; abort_cyc = -100; ended = 1'b0;
        for (int k = 0; k < 400 && !ended; k++) begin
            abort = (cyc == abort_cyc);
            if (i < len && stall == 0) begin
                valid = 1'b1; word_in = words[i];
            end else begin
                valid = 1'b0;
                if (stall > 0) stall--;
            end
            @(negedge clk);
            halt_cyc += int'(inst ? halt_b : halt_a);
            en_cnt   += int'(inst ? en_b : en_a);
            if (inst ? (done_b || ab_b) : (done_a || ab_a)) begin
                ended = 1'b1; t_done = cyc;
            end
            acc = (inst ? rdy_b : rdy_a) && valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (i == abort_idx) abort_cyc = cyc + abort_dly - 1;
                i++;
                stall = gap;
            end
        end
        abort = 1'b0; valid = 1'b0;
        if (!ended) begin
            checks++; failures++;
            $display("FAIL load_timeout actual=no_end expected=done_or_aborted");
        end
    endtask

    initial begin
        int t, h, n;
        bit found;
        rst_n = 1'b1; ls_a = 1'b0; ls_b = 1'b0; abort = 1'b0; valid = 1'b0;
        load_len = 16'd0; word_in = 16'd0;
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001; words[3] = 16'h5A5A;
        last_cs[0] = 16'd0; last_cs[1] = 16'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_halt_en_rw", {29'd0, halt_a, en_a, rw_a}, 32'd0);
        chk("rst_data_addr", {data_a, addr_a}, 32'd0);
        chk("rst_rdy_busy_done_ab", {28'd0, rdy_a, busy_a, done_a, ab_a}, 32'd0);
        chk("rst_checksum", {16'd0, cs_a}, 32'd0);
        chk("rst_wrap_addr", {16'd0, addr_b}, 32'h0000_FFFE);
        @(posedge clk); #1;

        // Basic 3-word load.
        expect_load(0, 16'h0000, 3, 3, 3, 0);
        run_load(0, 3, 0, -1, 0, t, h, n);
        chk("basic_done_cycle", t, 32'd14);
        chk("basic_halt_cycles", h, 32'd14);
        chk("basic_en_count", n, 32'd3);
        chk("basic_checksum", {16'd0, cs_a}, 32'h0000_BE02);
        chk("basic_final_addr", {16'd0, addr_a}, 32'd3);
        chk("basic_halt_released", {31'd0, halt_a}, 32'd0);

        // Stream stalls five cycles after each accepted word.
        expect_load(0, 16'h0000, 3, 3, 3, 0);
        run_load(0, 3, 5, -1, 0, t, h, n);
        chk("stall_done_cycle", t, 32'd18);
        chk("stall_en_count", n, 32'd3);
        chk("stall_checksum", {16'd0, cs_a}, 32'h0000_BE02);

        // Zero-length load: immediate DONE, checksum untouched.
        expect_load(0, 16'h0000, 0, 0, 0, 0);
        run_load(0, 0, 0, -1, 0, t, h, n);
        chk("zero_done_cycle", t, 32'd0);
        chk("zero_halt_cycles", h, 32'd0);
        chk("zero_en_count", n, 32'd0);
        chk("zero_checksum_kept", {16'd0, cs_a}, 32'h0000_BE02);

        // Address wrap from FFFE.
        expect_load(1, 16'hFFFE, 3, 3, 3, 0);
        run_load(1, 3, 0, -1, 0, t, h, n);
        chk("wrap_en_count", n, 32'd3);
        chk("wrap_final_addr", {16'd0, addr_b}, 32'h0000_0001);
        chk("wrap_checksum", {16'd0, cs_b}, 32'h0000_BE02);

        // Abort during WR_STROBE of word 2 of 4: word 2 still lands.
        expect_load(0, 16'h0000, 4, 2, 2, 1);
        run_load(0, 4, 0, 1, 2, t, h, n);
        chk("abort_strobe_en_count", n, 32'd2);
        chk("abort_strobe_checksum", {16'd0, cs_a}, 32'h0000_BE01);
        chk("abort_strobe_addr", {16'd0, addr_a}, 32'd2);
        chk("abort_strobe_halt_low", {31'd0, halt_a}, 32'd0);

        // Abort during WR_SETUP of word 2: pending write dropped.
        expect_load(0, 16'h0000, 4, 1, 2, 1);
        run_load(0, 4, 0, 1, 1, t, h, n);
        chk("abort_setup_en_count", n, 32'd1);
        chk("abort_setup_checksum", {16'd0, cs_a}, 32'h0000_BE01);
        chk("abort_setup_addr", {16'd0, addr_a}, 32'd1);

        // Asynchronous reset in the middle of the first strobe.
        exp_wr_a.push_back({16'h0000, words[0]});
        load_len = 16'd3; ls_a = 1'b1;
        @(posedge clk); #1;
        ls_a = 1'b0; valid = 1'b1; word_in = words[0];
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (en_a) found = 1'b1;
        end
        valid = 1'b0;
        if (!found) begin
            checks++; failures++;
            $display("FAIL reset_no_strobe actual=0 expected=1");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_halt_en_busy", {29'd0, halt_a, en_a, busy_a}, 32'd0);
        chk("rst_mid_checksum", {16'd0, cs_a}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_cs[0] = 16'd0;
        chk("rst_mid_no_pending_writes", exp_wr_a.size(), 32'd0);
        @(posedge clk); #1;

        expect_load(0, 16'h0000, 3, 3, 3, 0);
        run_load(0, 3, 0, -1, 0, t, h, n);
        chk("post_rst_done_cycle", t, 32'd14);
        chk("post_rst_en_count", n, 32'd3);
        chk("post_rst_checksum", {16'd0, cs_a}, 32'h0000_BE02);

        repeat (2) @(posedge clk);
        chk("a_writes_drained", exp_wr_a.size() + exp_end_a.size(), 32'd0);
        chk("b_writes_drained", exp_wr_b.size() + exp_end_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
